// File: rtl/r200_fetchq.sv
// Instruction fetch front end: issues imem word fetches and queues returned instructions with their PCs.
// Latency: 1 cycle from imem_rvalid to out_valid with an empty queue; 1 instruction/cycle sustained.
// Backpressure: stall holds the head entry; requests stop once queued + live in-flight words fill DEPTH.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   imem_req/addr/gnt                request channel (addr registered, word aligned)
//   imem_rvalid/rdata                in-order responses, >= 1 cycle after grant
//   redirect/redirect_pc             taken branch/jump: flush queue, kill in-flight responses
//   stall                            consumer not ready
//   out_valid/instrn/pc/pcp4         head of queue (combinational view of the head entry)
module r200_fetchq #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_instrn,
  output logic [31:0] out_pc,
  output logic [31:0] out_pcp4
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (MAX_OUTSTANDING > 2) ? 2 : 1;
  localparam int TD = 1 << TW;

  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  logic [1:0]    outstanding;
  logic [1:0]    outstanding_nxt;
  logic [1:0]    kill;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   q_pc     [DEPTH];
  logic [31:0]   q_instrn [DEPTH];

  // PC tags of in-flight requests, popped in response order.
  logic [31:0]   tag_pc   [TD];
  logic [TW-1:0] tag_wr;
  logic [TW-1:0] tag_rd;

  logic       grant;
  logic       resp;
  logic       push;
  logic       pop;
  logic [7:0] occ;
  logic       unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  // Occupancy counts live in-flight words too, so a response always has a free slot.
  assign occ      = 8'(count) + 8'(outstanding) - 8'(kill);
  assign imem_req = rst_n && !redirect &&
                    (outstanding < 2'(MAX_OUTSTANDING)) && (occ < 8'(DEPTH));
  assign imem_addr = fetch_pc;

  assign grant = imem_req && imem_gnt;
  assign resp  = imem_rvalid;
  // A response in a redirect cycle is stale by definition.
  assign push  = resp && (kill == 2'd0) && !redirect;
  assign pop   = out_valid && !stall;

  assign out_valid  = (count != '0);
  assign out_pc     = q_pc[rd_ptr];
  assign out_instrn = q_instrn[rd_ptr];
  assign out_pcp4   = out_pc + 32'd4;

  always_comb begin
    outstanding_nxt = outstanding;
    if (grant && !resp)      outstanding_nxt = outstanding + 2'd1;
    else if (!grant && resp) outstanding_nxt = outstanding - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= {RESET_PC[31:2], 2'b00};
      count       <= '0;
      outstanding <= 2'd0;
      kill        <= 2'd0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]     <= '0;
        q_instrn[i] <= '0;
      end
      for (int i = 0; i < TD; i++) tag_pc[i] <= '0;
    end else begin
      outstanding <= outstanding_nxt;

      if (grant) begin
        tag_pc[tag_wr] <= fetch_pc;
        tag_wr <= (tag_wr == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr + TW'(1);
      end
      if (resp) begin
        tag_rd <= (tag_rd == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd + TW'(1);
      end

      if (redirect) begin
        // No grant can happen this cycle, so every surviving in-flight word is stale.
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        kill     <= outstanding_nxt;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (resp && (kill != 2'd0)) kill <= kill - 2'd1;
        if (push) begin
          q_pc[wr_ptr]     <= tag_pc[tag_rd];
          q_instrn[wr_ptr] <= imem_rdata;
          wr_ptr           <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // A response with nothing in flight means the memory model is broken.
  a_rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) imem_rvalid |-> (outstanding != 2'd0));

endmodule

// File: tb/tb_r200_fetchq.sv
module tb_r200_fetchq;
  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] MAGIC    = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        out_valid;
  logic [31:0] out_instrn;
  logic [31:0] out_pc;
  logic [31:0] out_pcp4;

  always #5 clk = ~clk;

  r200_fetchq dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .out_valid(out_valid), .out_instrn(out_instrn), .out_pc(out_pc), .out_pcp4(out_pcp4)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: memory-side queue of granted words tagged with a redirect epoch,
  // and the ordered list of instructions the consumer should see.
  logic [31:0] pend_addr[$];
  int          pend_cyc[$];
  int          pend_ep[$];
  logic [31:0] bq[$];
  logic [31:0] m_fetch;
  int          epoch;
  int          cyc = 0;
  int          gnt_pct = 100;
  int          rv_pct = 100;

  logic        pop_vld;
  logic [31:0] pop_pc;
  logic [31:0] pop_pcp4;
  logic        gnt_seen;
  logic [31:0] gnt_addr;

  task automatic model_reset();
    pend_addr.delete(); pend_cyc.delete(); pend_ep.delete();
    bq.delete();
    m_fetch = RESET_PC;
    epoch = 0;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle();
    logic rv;
    logic exp_req;
    int   live;
    rv = (pend_addr.size() > 0) && (pend_cyc[0] < cyc) && ($urandom_range(99) < rv_pct);
    imem_rvalid = rv;
    imem_rdata  = rv ? (pend_addr[0] ^ MAGIC) : $urandom;
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    #1;
    live = 0;
    foreach (pend_ep[i]) if (pend_ep[i] == epoch) live++;
    exp_req = !redirect && (pend_addr.size() < MAXO) && (bq.size() + live < DEPTH);
    checks++;
    if (imem_req !== exp_req) begin
      failures++; $display("FAIL cyc%0d imem_req got=%b exp=%b", cyc, imem_req, exp_req);
    end
    checks++;
    if (imem_addr !== m_fetch) begin
      failures++; $display("FAIL cyc%0d imem_addr got=%h exp=%h", cyc, imem_addr, m_fetch);
    end
    checks++;
    if (out_valid !== (bq.size() != 0)) begin
      failures++; $display("FAIL cyc%0d out_valid got=%b exp=%b", cyc, out_valid, bq.size() != 0);
    end
    if (bq.size() != 0) begin
      checks++;
      if (out_pc !== bq[0]) begin
        failures++; $display("FAIL cyc%0d out_pc got=%h exp=%h", cyc, out_pc, bq[0]);
      end
      checks++;
      if (out_instrn !== (bq[0] ^ MAGIC)) begin
        failures++; $display("FAIL cyc%0d out_instrn got=%h exp=%h", cyc, out_instrn, bq[0] ^ MAGIC);
      end
      checks++;
      if (out_pcp4 !== bq[0] + 32'd4) begin
        failures++; $display("FAIL cyc%0d out_pcp4 got=%h exp=%h", cyc, out_pcp4, bq[0] + 32'd4);
      end
    end
    pop_vld  = (bq.size() != 0) && !stall && !redirect;
    pop_pc   = out_pc;
    pop_pcp4 = out_pcp4;
    gnt_seen = imem_req && imem_gnt;
    gnt_addr = imem_addr;
    @(posedge clk);
    if (pop_vld) void'(bq.pop_front());
    if (rv) begin
      logic [31:0] a;
      int e;
      a = pend_addr.pop_front(); void'(pend_cyc.pop_front()); e = pend_ep.pop_front();
      if (!redirect && e == epoch) bq.push_back(a);
    end
    if (gnt_seen) begin
      pend_addr.push_back(gnt_addr); pend_cyc.push_back(cyc); pend_ep.push_back(epoch);
      m_fetch = m_fetch + 32'd4;
    end
    if (redirect) begin
      bq.delete();
      epoch++;
      m_fetch = {redirect_pc[31:2], 2'b00};
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0; stall = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (imem_addr !== RESET_PC) begin failures++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RESET_PC); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    checks++; if (out_instrn !== 32'h0) begin failures++; $display("FAIL reset_instrn got=%h exp=0", out_instrn); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_stream();
    int n_pop = 0;
    int first = -1;
    int gi = 0;
    logic [31:0] exp = RESET_PC;
    gnt_pct = 100; rv_pct = 100; stall = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (gnt_seen && gi < 4) begin
        checks++;
        if (gnt_addr !== 32'(gi * 4)) begin
          failures++; $display("FAIL stream_addr got=%h exp=%h", gnt_addr, 32'(gi * 4));
        end
        gi++;
      end
      if (pop_vld) begin
        checks++;
        if (pop_pc !== exp) begin failures++; $display("FAIL stream_pc got=%h exp=%h", pop_pc, exp); end
        exp = exp + 32'd4;
        if (first < 0) first = i;
        n_pop++;
      end
    end
    checks++;
    if (first != 2 || n_pop != 20 - first) begin
      failures++; $display("FAIL stream_rate got_first=%0d got_pops=%0d exp_first=2 exp_pops=18", first, n_pop);
    end
  endtask

  task automatic test_stall();
    do_reset();
    gnt_pct = 100; rv_pct = 100; stall = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req got=%b exp=0", imem_req); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      failures++; $display("FAIL stall_head got=%b/%h exp=1/00000000", out_valid, out_pc);
    end
    stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (i < 5) begin
        checks++;
        if (!pop_vld || pop_pc !== 32'(i * 4)) begin
          failures++; $display("FAIL stall_release got=%b/%h exp=1/%h", pop_vld, pop_pc, 32'(i * 4));
        end
      end
    end
  endtask

  task automatic test_redirect();
    logic got = 1'b0;
    do_reset();
    gnt_pct = 100; rv_pct = 100; stall = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    rv_pct = 0;
    cycle();
    redirect = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect = 1'b0; rv_pct = 100;
    checks++;
    if (imem_addr !== 32'h100) begin failures++; $display("FAIL redir_addr got=%h exp=00000100", imem_addr); end
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (pop_vld && !got) begin
        got = 1'b1;
        checks++;
        if (pop_pc !== 32'h100) begin failures++; $display("FAIL redir_first got=%h exp=00000100", pop_pc); end
      end
    end
    checks++;
    if (!got) begin failures++; $display("FAIL redir_timeout got=none exp=00000100"); end
  endtask

  task automatic test_redirect_rvalid();
    logic [31:0] exp = 32'h200;
    do_reset();
    gnt_pct = 100; rv_pct = 100; stall = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    redirect = 1'b1; redirect_pc = 32'h80;
    cycle();
    redirect = 1'b0;
    if (pop_vld) begin checks++; failures++; $display("FAIL redir2_gap got=%h exp=none", pop_pc); end
    cycle();
    redirect = 1'b1; redirect_pc = 32'h200;
    cycle();
    redirect = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (pop_vld) begin
        checks++;
        if (pop_pc !== exp) begin failures++; $display("FAIL redir2_pc got=%h exp=%h", pop_pc, exp); end
        exp = exp + 32'd4;
      end
    end
    checks++;
    if (exp == 32'h200) begin failures++; $display("FAIL redir2_none got=none exp=00000200"); end
  endtask

  task automatic test_misaligned();
    logic got = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    cycle();
    redirect = 1'b0;
    checks++;
    if (imem_addr !== 32'h100) begin failures++; $display("FAIL misalign_addr got=%h exp=00000100", imem_addr); end
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (pop_vld && !got) begin
        got = 1'b1;
        checks++;
        if (pop_pc !== 32'h100) begin failures++; $display("FAIL misalign_pc got=%h exp=00000100", pop_pc); end
      end
    end
    checks++;
    if (!got) begin failures++; $display("FAIL misalign_timeout got=none exp=00000100"); end
  endtask

  task automatic test_wrap();
    logic gd = 1'b0;
    logic got = 1'b0;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect = 1'b0;
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr0 got=%h exp=fffffffc", imem_addr); end
    for (int i = 0; i < 6 && !gd; i++) begin
      cycle();
      if (gnt_seen) gd = 1'b1;
    end
    checks++;
    if (!gd || imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr1 got=%b/%h exp=1/00000000", gd, imem_addr); end
    for (int i = 0; i < 8 && !got; i++) begin
      cycle();
      if (pop_vld) begin
        got = 1'b1;
        checks++;
        if (pop_pc !== 32'hFFFF_FFFC || pop_pcp4 !== 32'h0) begin
          failures++; $display("FAIL wrap_pcp4 got=%h/%h exp=fffffffc/00000000", pop_pc, pop_pcp4);
        end
      end
    end
    checks++;
    if (!got) begin failures++; $display("FAIL wrap_timeout got=none exp=fffffffc"); end
  endtask

  task automatic test_random();
    gnt_pct = 70; rv_pct = 60;
    for (int i = 0; i < 400; i++) begin
      stall       = ($urandom_range(99) < 30);
      redirect    = ($urandom_range(99) < 4);
      redirect_pc = $urandom;
      cycle();
    end
    redirect = 1'b0; stall = 1'b0;
  endtask

  task automatic test_async_reset();
    gnt_pct = 100; rv_pct = 100; stall = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL areset_pre got=%b exp=1", out_valid); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b exp=0", out_valid); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL areset_req got=%b exp=0", imem_req); end
    imem_rvalid = 1'b0; imem_gnt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle();
    checks++;
    if (!gnt_seen || gnt_addr !== RESET_PC) begin
      failures++; $display("FAIL areset_restart got=%b/%h exp=1/%h", gnt_seen, gnt_addr, RESET_PC);
    end
    for (int i = 0; i < 6; i++) cycle();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_rvalid();
    test_misaligned();
    test_wrap();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/r200_fetchq.md
Name: r200_fetchq

Overview:
Instruction fetch front end with a prefetch queue. It issues word fetches to instruction memory over a request/grant/response handshake, buffers the returned instructions with their PCs, and presents them one per cycle to the IF/ID pipeline register. A redirect input from PC control handles taken branches and jumps: it flushes the queue and discards responses that are still in flight. Decode stalls back-pressure the block through the stall input.

Parameters:
DEPTH, 4, number of queue entries (power of two, at least 2).
MAX_OUTSTANDING, 2, maximum number of accepted imem requests without a response (1 to 3).
RESET_PC, 32'h00000000, fetch address after reset.

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  reset; asynchronous, active-low
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, word aligned
imem_gnt  in  1  request accepted this cycle (qualified by imem_req)
imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after grant
imem_rdata  in  32  instruction word
redirect  in  1  one-cycle pulse for a taken branch or jump
redirect_pc  in  32  new fetch PC (bits [1:0] ignored)
stall  in  1  consumer not ready; hold the head entry
out_valid  out  1  head entry valid
out_instrn  out  32  head instruction
out_pc  out  32  head PC
out_pcp4  out  32  out_pc + 4, modulo 2^32

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - fetch_pc = RESET_PC.
  - count, outstanding, kill = 0; read/write pointers = 0.
  - imem_req = 0, out_valid = 0, out_instrn = 0, out_pc = 0.
  - imem_addr = RESET_PC.
- Reset asserted mid-operation drops every queued entry and every in-flight request. After release, responses to pre-reset requests are not expected.
- imem_addr = {fetch_pc[31:2], 2'b00}, registered.
- imem_req = !redirect && (outstanding < MAX_OUTSTANDING) && (count + (outstanding - kill) < DEPTH).
  - Space is reserved for every live in-flight request, so a response never meets a full queue.
- Grant (imem_req && imem_gnt):
  - outstanding increments.
  - The issue PC is pushed into an in-order PC tag FIFO of depth MAX_OUTSTANDING.
  - fetch_pc += 4, wrapping at 2^32.
- Response (imem_rvalid):
  - outstanding decrements and the PC tag FIFO pops.
  - If kill > 0: kill decrements and the data is discarded.
  - Otherwise {tag PC, imem_rdata} is written at the write pointer and count increments.
- Grant and response in the same cycle leave outstanding unchanged. The tag FIFO pushes and pops together.
- Pop: when out_valid && !stall, the read pointer advances and count decrements.
  - Push and pop in the same cycle leave count unchanged, including when count = DEPTH.
- out_valid = (count != 0). The out_* fields are driven combinationally from the head entry.
  - While stall is high, the head entry is held stable.
- Pointers wrap modulo DEPTH.
- Redirect cycle:
  - Queue is flushed: count = 0, pointers reset.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - kill = outstanding after this cycle's response is accounted for.
  - imem_req = 0.
  - A response arriving in the redirect cycle is dropped.
  - out_valid is low from the next cycle until the first post-redirect response is enqueued.
- Redirect while kill > 0 sets kill to the total outstanding count. No stale word ever reaches the queue.
- Back-to-back redirects: the last one wins.
- Latency: 1 cycle from rvalid to out_valid with an empty queue. Throughput is 1 instruction/cycle when the memory sustains it.
- Unsupported conditions: imem_rvalid with outstanding = 0 is illegal. A simulation assertion flags it.

Test Plan:
- Reset release, memory returns mem[a] = a ^ 32'hA5A5A5A5 one cycle after each grant, stall = 0. Required: imem_addr sequence 0, 4, 8, 12, ...; out_pc 0, 4, 8 in order with matching out_instrn; out_pcp4 = out_pc + 4; one output per cycle after the first.
- Hold stall high with a continuous grant. Required: count reaches DEPTH = 4; imem_req drops once count + live outstanding = 4; head stays at pc 0. Release stall: pcs 0, 4, 8, 12, 16 emerge with no gap and no duplicate.
- Two requests outstanding (pcs 8 and 12), then redirect_pc = 32'h100. Required: both responses discarded; next out_pc = 32'h100; imem_addr = 32'h100 in the cycle after the redirect.
- Redirect in the same cycle as an rvalid, then a second redirect to 32'h200 two cycles later. Required: only pc 32'h200 and onward appear at out_pc.
- Redirect with redirect_pc = 32'h00000103. Required: fetch begins at 32'h100.
- Fetch starting at 32'hFFFFFFFC. Required: next imem_addr = 0; out_pcp4 = 0.
- Assert rst_n low mid-stream, asynchronous to clk. Required: out_valid and imem_req go low immediately; fetch restarts at RESET_PC after release.
